sd_cmd_engine: RTL
==================

// Module: sd_cmd_engine
// PURPOSE
//  Parametrised SD/SDIO command-line engine. Host logic posts a command (index + argument);
//  the block generates sd_clk, serialises the 48-bit frame with computed CRC7, then captures
//  a 48-bit or 136-bit response, checking CRC, end bit and timeout. It sits between the
//  card-init/transfer FSM and the tristate CMD pad, replacing fixed-frame bit-banged logic.
// PARAMETERS
//  DIV_W        8    width of runtime clock divider input
//  NCR_MAX      64   max sd_clk cycles from command end bit to response start bit
//  NCC_GAP      8    trailing sd_clk cycles after each transaction, CMD released
// PORTS
//  clk          in   1      system clock (27 MHz on board)
//  rst_n        in   1      asynchronous, active-low reset
//  clk_div      in   DIV_W  sd_clk half-period in clk cycles, min 1; sampled at cmd accept
//  cmd_valid    in   1      command request
//  cmd_ready    out  1      high in IDLE only; accept = cmd_valid & cmd_ready
//  cmd_index    in   6      command index
//  cmd_arg      in   32     command argument
//  resp_type    in   2      0 none, 1 R48 + CRC check, 2 R48 no CRC (R3), 3 R136 (R2)
//  done         out  1      one-clk pulse at end of transaction (after NCC gap)
//  timeout      out  1      valid with done: no start bit within NCR_MAX sd_clk cycles
//  crc_err      out  1      valid with done: CRC7 mismatch (types 1, 3 only)
//  end_err      out  1      valid with done: response end bit read as 0
//  resp_data    out  128    R48: [37:0] = {index, arg}, [127:38] = 0; R136: bits 127:0 after 8-bit header
//  sd_clk       out  1      SD clock, idle low, runs only while busy
//  sd_cmd_o     out  1      CMD drive value
//  sd_cmd_oe    out  1      CMD output enable (pad: oe ? o : z)
//  sd_cmd_i     in   1      CMD pad input
// BEHAVIOUR
//  Reset: sd_clk=0, sd_cmd_o=1, sd_cmd_oe=0, done/timeout/crc_err/end_err=0, resp_data=0, state IDLE.
//  Clock gen: divider counter produces rise/fall strobes every clk_div clk cycles while not IDLE.
//   CMD is driven on sd_clk falling edge and sampled on rising edge.
//  Frame: {0, 1, cmd_index, cmd_arg, crc7, 1}; CRC7 poly x^7+x^3+1, init 0, over first 40 bits.
//  FSM:
//   IDLE  -> SEND on accept; latch index/arg/type/div; oe=1, cmd_o=1; clear flags.
//   SEND  -> 48 bits MSB first, one per falling edge; after end bit oe=0 on the next falling edge;
//            -> WAIT if type != 0, else GAP.
//   WAIT  -> sample cmd_i each rise; 0 seen -> RECV (start bit counted);
//            NCR_MAX rises without 0 -> timeout=1, GAP.
//   RECV  -> shift in remaining 47 (R48) or 135 (R136) bits on rises; running CRC7 over bits
//            after header (R48: bits 47..8; R136: bits 127..8 of payload); end bit checked -> GAP.
//   GAP   -> NCC_GAP further sd_clk cycles, CMD released -> DONE.
//   DONE  -> done=1 for one clk, flags/resp_data stable until next accept -> IDLE, sd_clk held low.
//  Flags, resp_data: updated only at DONE, hold otherwise; cleared at next accept.
//  Type 2: crc_err forced 0; end bit still checked. Type 0: timeout/crc_err/end_err stay 0.
//  cmd_valid while busy: ignored (cmd_ready=0). clk_div=0: treated as 1.
//  rst_n asserted mid-transaction: immediate return to reset values, CMD released, no done.
// STRUCTURE
//  sd_defs.vh (shared include): RESP_NONE/R48/R48_NOCRC/R136 codes, FSM state encodings,
//   CMD_FRAME_BITS=48, R136_BITS=136, CRC7_POLY=7'h09.
//  Sub-module sd_crc7: serial CRC7 (clr, en, bit_in, crc[6:0]); instanced once, shared
//   between TX and RX (cleared at SEND and RECV entry).
// TESTING
//  CMD0, arg 0, type 0, div 34 -> CMD bits 0x400000000095, oe low after end bit,
//   done after 56 sd_clks, all flags 0.
//  CMD8, arg 0x1AA, type 1; card model replies 0x08000001AA13 after 5 clks ->
//   frame 0x48000001AA87, resp_data[37:0] = {6'h08, 32'h1AA}, flags 0.
//  Same, model reply CRC 0x12 -> crc_err=1; end bit 0 -> end_err=1.
//  CMD55 type 1, model silent -> timeout=1 after exactly 64 rises in WAIT, done follows NCC gap.
//  ACMD41 type 2, reply 0x3FC0FF8000FF (CRC 7F) -> crc_err=0, resp_data[31:0] = 32'hC0FF8000.
//  CMD2 type 3, 136-bit CID with valid CRC -> resp_data matches, flags 0;
//   then rst_n pulse mid-SEND -> oe=0, sd_clk=0 within 1 clk, no done.

Source files
------------

// File: rtl/sd_cmd_engine_pkg.sv
// rtl/sd_cmd_engine_pkg.sv - shared codes, frame sizes, FSM states and CRC7 step for the SD command engine
package sd_cmd_engine_pkg;

  localparam logic [1:0] RESP_NONE      = 2'd0;
  localparam logic [1:0] RESP_R48       = 2'd1;
  localparam logic [1:0] RESP_R48_NOCRC = 2'd2;
  localparam logic [1:0] RESP_R136      = 2'd3;

  localparam int         CMD_FRAME_BITS = 48;
  localparam int         R136_BITS      = 136;
  localparam logic [6:0] CRC7_POLY      = 7'h09;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_RECV,
    ST_GAP,
    ST_DONE
  } state_t;

  // one MSB-first step of x^7+x^3+1
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    return {crc[5:0], 1'b0} ^ ((bit_in ^ crc[6]) ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 accumulator shared by command TX and response RX
module sd_crc7
  import sd_cmd_engine_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic [6:0] r_crc;

  // clear wins over accumulate so a new frame never inherits old state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  r_crc <= 7'h00;
    else if (clr) r_crc <= 7'h00;
    else if (en)  r_crc <= crc7_step(r_crc, bit_in);
  end

  assign crc = r_crc;

endmodule

// File: rtl/sd_cmd_engine.sv
// rtl/sd_cmd_engine.sv - SD command line engine: sd_clk gen, CMD frame TX, response capture
module sd_cmd_engine
  import sd_cmd_engine_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int NCR_MAX = 64,
  parameter int NCC_GAP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [5:0]       cmd_index,
  input  logic [31:0]      cmd_arg,
  input  logic [1:0]       resp_type,
  output logic             done,
  output logic             timeout,
  output logic             crc_err,
  output logic             end_err,
  output logic [127:0]     resp_data,
  output logic             sd_clk,
  output logic             sd_cmd_o,
  output logic             sd_cmd_oe,
  input  logic             sd_cmd_i
);

  state_t           r_state, w_state_nx;
  logic [DIV_W-1:0] r_div, r_div_cnt;
  logic             r_sd_clk, r_cmd_o, r_cmd_oe;
  logic [7:0]       r_cnt;
  logic [1:0]       r_type;
  logic [39:0]      r_tx;
  logic [127:0]     r_shift, r_resp;
  logic             r_to_p, r_crc_p, r_end_p;
  logic             r_timeout, r_crc_err, r_end_err;

  logic             w_active, w_tick, w_rise, w_fall, w_accept;
  logic             w_crc_clr, w_crc_en, w_crc_bit, w_tx_bit;
  logic [6:0]       w_crc;
  logic [2:0]       w_sel;
  logic [7:0]       w_n, w_rx_total;
  logic             w_rx_last, w_rx_crc_en;

  assign w_active    = (r_state == ST_SEND) || (r_state == ST_WAIT) ||
                       (r_state == ST_RECV) || (r_state == ST_GAP);
  assign w_tick      = w_active && (r_div_cnt == r_div - DIV_W'(1));
  assign w_rise      = w_tick && !r_sd_clk;
  assign w_fall      = w_tick && r_sd_clk;
  assign w_accept    = (r_state == ST_IDLE) && cmd_valid;
  // bits 0..39 come from the shift register, 40..46 are the CRC MSB first, 47 is the end bit
  assign w_sel       = 3'd6 - r_cnt[2:0];
  assign w_tx_bit    = (r_cnt < 8'd40) ? r_tx[39] : (r_cnt < 8'd47) ? w_crc[w_sel] : 1'b1;
  assign w_n         = r_cnt + 8'd1;
  assign w_rx_total  = (r_type == RESP_R136) ? 8'(R136_BITS) : 8'(CMD_FRAME_BITS);
  assign w_rx_last   = (w_n == w_rx_total);
  // R136 skips the 8-bit header; R48 covers start..arg (start bit is a no-op on a cleared CRC)
  assign w_rx_crc_en = (r_type == RESP_R136) ? (w_n >= 8'd9 && w_n <= 8'd128) : (w_n <= 8'd40);

  // route the shared CRC between the outgoing frame and the incoming response
  always_comb begin
    w_crc_clr = w_accept || ((r_state == ST_WAIT) && w_rise && !sd_cmd_i);
    w_crc_en  = 1'b0;
    w_crc_bit = 1'b0;
    if ((r_state == ST_SEND) && w_fall && (r_cnt < 8'd40)) begin
      w_crc_en  = 1'b1;
      w_crc_bit = r_tx[39];
    end else if ((r_state == ST_RECV) && w_rise && w_rx_crc_en) begin
      w_crc_en  = 1'b1;
      w_crc_bit = sd_cmd_i;
    end
  end

  sd_crc7 u_crc7 (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_crc_clr),
    .en     (w_crc_en),
    .bit_in (w_crc_bit),
    .crc    (w_crc)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  // next state and handshake outputs
  always_comb begin
    w_state_nx = r_state;
    cmd_ready  = 1'b0;
    done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_nx = ST_SEND;
      end
      ST_SEND: if (w_fall && (r_cnt == 8'(CMD_FRAME_BITS)))
                 w_state_nx = (r_type == RESP_NONE) ? ST_GAP : ST_WAIT;
      ST_WAIT: if (w_rise) begin
                 if (!sd_cmd_i)                     w_state_nx = ST_RECV;
                 else if (r_cnt == 8'(NCR_MAX - 1)) w_state_nx = ST_GAP;
               end
      ST_RECV: if (w_rise && w_rx_last) w_state_nx = ST_GAP;
      ST_GAP:  if (w_fall && (r_cnt == 8'(NCC_GAP - 1))) w_state_nx = ST_DONE;
      ST_DONE: begin
        done       = 1'b1;
        w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // sd_clk divider: runs only while busy, always restarts low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_sd_clk  <= 1'b0;
    end else if (!w_active) begin
      r_div_cnt <= '0;
      r_sd_clk  <= 1'b0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_sd_clk  <= ~r_sd_clk;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // frame shifting, response capture and result publication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= DIV_W'(1);
      r_type    <= RESP_NONE;
      r_tx      <= '0;
      r_cmd_o   <= 1'b1;
      r_cmd_oe  <= 1'b0;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_to_p    <= 1'b0;
      r_crc_p   <= 1'b0;
      r_end_p   <= 1'b0;
      r_timeout <= 1'b0;
      r_crc_err <= 1'b0;
      r_end_err <= 1'b0;
      r_resp    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (cmd_valid) begin
          r_type    <= resp_type;
          r_div     <= (clk_div == '0) ? DIV_W'(1) : clk_div;
          r_tx      <= {2'b01, cmd_index, cmd_arg};
          r_cmd_oe  <= 1'b1;
          r_cmd_o   <= 1'b1;
          r_cnt     <= '0;
          r_shift   <= '0;
          r_to_p    <= 1'b0;
          r_crc_p   <= 1'b0;
          r_end_p   <= 1'b0;
          r_timeout <= 1'b0;
          r_crc_err <= 1'b0;
          r_end_err <= 1'b0;
          r_resp    <= '0;
        end
        ST_SEND: if (w_fall) begin
          if (r_cnt == 8'(CMD_FRAME_BITS)) begin
            r_cmd_oe <= 1'b0;
            r_cmd_o  <= 1'b1;
            // the release edge already counts as the first gap cycle
            r_cnt    <= (r_type == RESP_NONE) ? 8'd1 : 8'd0;
          end else begin
            r_cmd_o <= w_tx_bit;
            r_cnt   <= w_n;
            if (r_cnt < 8'd40) r_tx <= {r_tx[38:0], 1'b0};
          end
        end
        ST_WAIT: if (w_rise) begin
          if (!sd_cmd_i) begin
            r_cnt <= 8'd1;
          end else if (r_cnt == 8'(NCR_MAX - 1)) begin
            r_to_p <= 1'b1;
            r_cnt  <= '0;
          end else begin
            r_cnt <= w_n;
          end
        end
        ST_RECV: if (w_rise) begin
          r_shift <= {r_shift[126:0], sd_cmd_i};
          if (w_rx_last) begin
            r_cnt   <= '0;
            r_end_p <= !sd_cmd_i;
            r_crc_p <= (r_type != RESP_R48_NOCRC) && (r_shift[6:0] != w_crc);
          end else begin
            r_cnt <= w_n;
          end
        end
        ST_GAP: if (w_fall) begin
          r_cnt <= w_n;
          if (r_cnt == 8'(NCC_GAP - 1)) begin
            r_timeout <= r_to_p;
            r_crc_err <= r_crc_p;
            r_end_err <= r_end_p;
            r_resp    <= (r_type == RESP_R136) ? r_shift : {90'b0, r_shift[45:8]};
          end
        end
        default: ;
      endcase
    end
  end

  assign sd_clk    = r_sd_clk;
  assign sd_cmd_o  = r_cmd_o;
  assign sd_cmd_oe = r_cmd_oe;
  assign timeout   = r_timeout;
  assign crc_err   = r_crc_err;
  assign end_err   = r_end_err;
  assign resp_data = r_resp;

endmodule
